// File: rtl/if_id_if.sv
// Bundle between hazard/fetch control, instruction memory and the IF/ID stage.
// master drives control and memory data; slave is the stage itself.
interface if_id_if;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_Flush;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic [31:0] instr_mem_data;
    logic [31:0] instr_addr;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic [5:0]  IF_ID_Opcode;
    logic [4:0]  IF_ID_RegisterRs;
    logic [4:0]  IF_ID_RegisterRt;
    logic [4:0]  IF_ID_RegisterRd;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output PCWrite, IF_ID_Write, IF_Flush, PCSrc, branch_target, instr_mem_data,
        input  instr_addr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, IF_ID_Opcode,
               IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
               stall_count, flush_count
    );

    modport slave (
        input  PCWrite, IF_ID_Write, IF_Flush, PCSrc, branch_target, instr_mem_data,
        output instr_addr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, IF_ID_Opcode,
               IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
               stall_count, flush_count
    );
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC register plus IF/ID pipeline register with stall/flush control
// and saturating stall/flush event counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic   clk,
    input  logic   rst_n,
    if_id_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_plus4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Wraps modulo 2^32 naturally.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (bus.PCSrc)
            pc_d = {bus.branch_target[31:2], 2'b00};
        else if (bus.PCWrite)
            pc_d = pc_plus4;
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bus.IF_Flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (bus.IF_ID_Write) begin
            instr_d = bus.instr_mem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // A redirect is not a stall even though PCWrite may be low.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.PCWrite && !bus.PCSrc)
            stall_cnt_d = sat_inc(stall_cnt_q);
        if (bus.IF_Flush)
            flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= {RESET_PC[31:2], 2'b00};
            pc4_q       <= 32'h0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.instr_addr       = pc_q;
    assign bus.IF_ID_PC4        = pc4_q;
    assign bus.IF_ID_Instr      = instr_q;
    assign bus.IF_ID_Valid      = valid_q;
    assign bus.IF_ID_Opcode     = instr_q[31:26];
    assign bus.IF_ID_RegisterRs = instr_q[25:21];
    assign bus.IF_ID_RegisterRt = instr_q[20:16];
    assign bus.IF_ID_RegisterRd = instr_q[15:11];
    assign bus.stall_count      = stall_cnt_q;
    assign bus.flush_count      = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, fetch, stall, redirect, wrap, saturation.
module tb_if_id_stage;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    if_id_if bus();

    if_id_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic flush,
                         input logic src, input logic [31:0] tgt, input logic [31:0] mem);
        bus.PCWrite        = pcw;
        bus.IF_ID_Write    = ifw;
        bus.IF_Flush       = flush;
        bus.PCSrc          = src;
        bus.branch_target  = tgt;
        bus.instr_mem_data = mem;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset, checked before the first clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_addr",  bus.instr_addr, 32'h0);
        check("rst_instr", bus.IF_ID_Instr, 32'h0);
        check("rst_pc4",   bus.IF_ID_PC4, 32'h0);
        check("rst_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
        check("rst_stall", {16'h0, bus.stall_count}, 32'h0);
        check("rst_flush", {16'h0, bus.flush_count}, 32'h0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8C220004);
        step();
        check("rst_hold_addr", bus.instr_addr, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Sequential fetch
        step();
        check("f1_addr",  bus.instr_addr, 32'h4);
        check("f1_instr", bus.IF_ID_Instr, 32'h8C220004);
        check("f1_pc4",   bus.IF_ID_PC4, 32'h4);
        check("f1_valid", {31'h0, bus.IF_ID_Valid}, 32'h1);
        check("f1_op",    {26'h0, bus.IF_ID_Opcode}, 32'h23);
        check("f1_rs",    {27'h0, bus.IF_ID_RegisterRs}, 32'h1);
        check("f1_rt",    {27'h0, bus.IF_ID_RegisterRt}, 32'h2);
        check("f1_rd",    {27'h0, bus.IF_ID_RegisterRd}, 32'h0);

        bus.instr_mem_data = 32'h00430820;
        step();
        check("f2_addr",  bus.instr_addr, 32'h8);
        check("f2_instr", bus.IF_ID_Instr, 32'h00430820);
        check("f2_pc4",   bus.IF_ID_PC4, 32'h8);
        check("f2_rd",    {27'h0, bus.IF_ID_RegisterRd}, 32'h1);

        // Load-use stall at PC=8
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10000002);
        step();
        check("st_addr",  bus.instr_addr, 32'h8);
        check("st_instr", bus.IF_ID_Instr, 32'h00430820);
        check("st_pc4",   bus.IF_ID_PC4, 32'h8);
        check("st_cnt",   {16'h0, bus.stall_count}, 32'h1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10000002);
        step();
        check("f3_addr",  bus.instr_addr, 32'hC);
        check("f3_instr", bus.IF_ID_Instr, 32'h10000002);
        check("f3_pc4",   bus.IF_ID_PC4, 32'hC);
        check("f3_stall", {16'h0, bus.stall_count}, 32'h1);

        // PC held, IF/ID re-latches the same address
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hAAAA0000);
        step();
        check("rl_addr",  bus.instr_addr, 32'hC);
        check("rl_instr", bus.IF_ID_Instr, 32'hAAAA0000);
        check("rl_pc4",   bus.IF_ID_PC4, 32'h10);
        check("rl_stall", {16'h0, bus.stall_count}, 32'h2);

        // PC advances, fetched word dropped
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h55555555);
        step();
        check("dr_addr",  bus.instr_addr, 32'h10);
        check("dr_instr", bus.IF_ID_Instr, 32'hAAAA0000);
        check("dr_pc4",   bus.IF_ID_PC4, 32'h10);

        // Branch redirect with flush overriding IF_ID_Write
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h00000043, 32'h77777777);
        step();
        check("br_addr",  bus.instr_addr, 32'h40);
        check("br_instr", bus.IF_ID_Instr, 32'h0);
        check("br_pc4",   bus.IF_ID_PC4, 32'h0);
        check("br_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
        check("br_flush", {16'h0, bus.flush_count}, 32'h1);
        check("br_stall", {16'h0, bus.stall_count}, 32'h2);

        // Full hold
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h99999999);
        step();
        check("hd_addr",  bus.instr_addr, 32'h40);
        check("hd_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
        check("hd_stall", {16'h0, bus.stall_count}, 32'h3);

        // Redirect without flush, then wrap past the top of memory
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0);
        step();
        check("rd_addr",  bus.instr_addr, 32'hFFFFFFFC);
        check("rd_stall", {16'h0, bus.stall_count}, 32'h3);
        check("rd_flush", {16'h0, bus.flush_count}, 32'h1);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
        step();
        check("wr_addr",  bus.instr_addr, 32'h0);
        check("wr_pc4",   bus.IF_ID_PC4, 32'h0);
        check("wr_instr", bus.IF_ID_Instr, 32'h12345678);
        check("wr_valid", {31'h0, bus.IF_ID_Valid}, 32'h1);

        // Mid-cycle asynchronous reset with a redirect pending
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h00000100, 32'h0);
        rst_n = 1'b0;
        #1;
        check("ar_addr",  bus.instr_addr, 32'h0);
        check("ar_instr", bus.IF_ID_Instr, 32'h0);
        check("ar_valid", {31'h0, bus.IF_ID_Valid}, 32'h0);
        check("ar_stall", {16'h0, bus.stall_count}, 32'h0);
        check("ar_flush", {16'h0, bus.flush_count}, 32'h0);
        step();
        check("ar_hold",  bus.instr_addr, 32'h0);

        // Stall counter saturation
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        check("sat_fffe", {16'h0, bus.stall_count}, 32'hFFFE);
        step();
        check("sat_ffff", {16'h0, bus.stall_count}, 32'hFFFF);
        step();
        check("sat_hold", {16'h0, bus.stall_count}, 32'hFFFF);
        check("sat_addr", bus.instr_addr, 32'h0);
        check("sat_flush", {16'h0, bus.flush_count}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
